sha1_core_wb: RTL and testbench
===============================

// Module: sha1_core_wb
// PURPOSE
//  SHA-1 hash engine (FIPS 180-4) with a Wishbone-classic 32-bit slave port, placed in the
//  user project area and driven by management-core firmware. Firmware loads one 512-bit block,
//  issues INIT (first block) or NEXT (subsequent block), polls STATUS and reads the 160-bit digest.
//  One SHA-1 round per clock; firmware signals progress on GPIO (outside this block).
// PARAMETERS
//  BASE_ADDR  32'h3000_0000  Wishbone base address; decode compares wbs_adr_i[31:8] with BASE_ADDR[31:8]
// PORTS
//  clock         in   1   sole clock; every register is clocked on its rising edge
//  resetb        in   1   asynchronous, active-low reset
//  wbs_cyc_i     in   1   Wishbone cycle
//  wbs_stb_i     in   1   Wishbone strobe
//  wbs_we_i      in   1   1 = write
//  wbs_sel_i     in   4   byte enables (write: only bytes with sel=1 update)
//  wbs_adr_i     in   32  byte address
//  wbs_dat_i     in   32  write data
//  wbs_dat_o     out  32  read data, valid while wbs_ack_o=1
//  wbs_ack_o     out  1   one-cycle acknowledge
//  irq_o         out  1   one-cycle pulse when a block completes
// BEHAVIOUR
//  Register map (offset): 0x00 CTRL W: bit0 INIT, bit1 NEXT (self-clearing pulses, read 0);
//   0x04 STATUS R: bit0 ready, bit1 digest_valid; 0x10..0x4C BLOCK[0..15] R/W (BLOCK[0]=W0, MSW first);
//   0x50..0x60 DIGEST[0..4] R-only = H0..H4. Unmapped/out-of-range reads return 0, writes ignored.
//  Bus: request = cyc&stb&decode hit; ack asserted the cycle after request, deasserted next cycle
//   (no back-to-back ack; a held request is acked every other cycle). Writes take effect at ack edge.
//  Reset: all BLOCK/H/working regs 0, ready=1, digest_valid=0, wbs_ack_o=0, wbs_dat_o=0, irq_o=0.
//  FSM IDLE -> ROUND -> FINAL -> IDLE.
//   IDLE: ready=1. CTRL write with INIT: H<=67452301,EFCDAB89,98BADCFE,10325476,C3D2E1F0 and start;
//    NEXT: start using current H. INIT and NEXT together: INIT wins. Start copies BLOCK[0..15]
//    into a 16-word schedule window, loads a..e from (new) H, t=0, ready=0, digest_valid=0.
//   ROUND (t=0..79, one per cycle): W_t = window[0] for t<16 else rotl1(w[t-3]^w[t-8]^w[t-14]^w[t-16]),
//    window shifts each round. f/K: t<20 Ch/5A827999; <40 Parity/6ED9EBA1; <60 Maj/8F1BBCDC; else Parity/CA62C1D6.
//    T=rotl5(a)+f+e+K+W_t mod 2^32; e<=d; d<=c; c<=rotl30(b); b<=a; a<=T. After t=79 -> FINAL.
//   FINAL (1 cycle): H_i <= H_i + {a..e}_i mod 2^32; ready=1, digest_valid=1, irq_o pulse -> IDLE.
//  Latency: ready returns 81 cycles after the CTRL-write ack edge (80 ROUND + 1 FINAL).
//  While busy: CTRL writes ignored; BLOCK writes accepted and do not affect the running hash;
//   DIGEST reads return current (pre-update) H; STATUS reads ready=0.
//  resetb low mid-hash aborts immediately to reset state; no partial digest is kept.
// STRUCTURE
//  Shared package sha1_pkg: H0..H4 init constants, K0..K3, register offsets, FSM state enum.
//  One natural sub-module: sha1_round (combinational f/K select, T, next a..e); bus, regs, FSM,
//  schedule window in the top.
// TESTING
//  1 "abc": BLOCK0=61626380, BLOCK1..14=0, BLOCK15=00000018, INIT -> after 81 cycles DIGEST=
//    a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d, digest_valid=1, one irq_o pulse.
//  2 empty msg: BLOCK0=80000000, rest 0, INIT -> da39a3ee 5e6b4b0d 3255bfef 95601890 afd80709.
//  3 two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmjklmnlmnomnopnopq": INIT blk1, NEXT blk2 ->
//    84983e44 1c3bd26e baae4aa1 f95129e5 e54670f1.
//  4 busy rules: during case 1, write CTRL=2 and BLOCK0=FFFFFFFF -> ignored/no effect, same digest;
//    STATUS reads 0 while busy.
//  5 reset at round 40: assert resetb low -> ready=1, digest_valid=0, DIGEST=0; rerun case 1 passes.
//  6 bus: read 0x80 -> 0, ack exactly one cycle; sel=4'b0001 write to BLOCK3 updates byte 0 only.

Source files
------------

// File: rtl/sha1_pkg.sv
// sha1_pkg: SHA-1 constants, Wishbone register word indices and FSM state type
// shared by the SHA-1 Wishbone core and its round logic.
package sha1_pkg;

    localparam logic [31:0] H_INIT [5] = '{
        32'h6745_2301, 32'hEFCD_AB89, 32'h98BA_DCFE, 32'h1032_5476, 32'hC3D2_E1F0
    };

    localparam logic [31:0] K0 = 32'h5A82_7999;
    localparam logic [31:0] K1 = 32'h6ED9_EBA1;
    localparam logic [31:0] K2 = 32'h8F1B_BCDC;
    localparam logic [31:0] K3 = 32'hCA62_C1D6;

    // Word indices (byte offset >> 2) within the 256-byte window
    localparam logic [5:0] IDX_CTRL   = 6'd0;
    localparam logic [5:0] IDX_STATUS = 6'd1;
    localparam logic [5:0] IDX_BLOCK  = 6'd4;
    localparam logic [5:0] IDX_DIGEST = 6'd20;
    localparam logic [5:0] IDX_END    = 6'd25;

    typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_FINAL} state_t;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

endpackage

// File: rtl/sha1_round.sv
// sha1_round: one combinational SHA-1 round; selects f/K from the round index
// and produces the next a..e working variables.
module sha1_round
    import sha1_pkg::*;
(
    input  logic [6:0]  t_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] c_i,
    input  logic [31:0] d_i,
    input  logic [31:0] e_i,
    input  logic [31:0] w_i,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [31:0] c_o,
    output logic [31:0] d_o,
    output logic [31:0] e_o
);

    logic [31:0] f, k;

    always_comb begin
        f   = (t_i < 7'd20) ? ((b_i & c_i) | (~b_i & d_i)) :
              (t_i < 7'd40) ? (b_i ^ c_i ^ d_i) :
              (t_i < 7'd60) ? ((b_i & c_i) | (b_i & d_i) | (c_i & d_i)) :
                              (b_i ^ c_i ^ d_i);
        k   = (t_i < 7'd20) ? K0 : (t_i < 7'd40) ? K1 : (t_i < 7'd60) ? K2 : K3;
        a_o = rotl(a_i, 5) + f + e_i + k + w_i;
        b_o = a_i;
        c_o = rotl(b_i, 30);
        d_o = c_i;
        e_o = d_i;
    end

endmodule

// File: rtl/sha1_core_wb.sv
// sha1_core_wb: SHA-1 engine behind a Wishbone-classic slave; one round per clock,
// firmware loads a 512-bit block, issues INIT/NEXT and reads H0..H4.
module sha1_core_wb
    import sha1_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        clock,
    input  logic        resetb,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        irq_o
);

    logic [31:0] blk_q [16];
    logic [31:0] win_q [16];
    logic [31:0] h_q   [5];
    logic [31:0] wv_q  [5];
    logic [31:0] hn    [5];
    logic [31:0] rnd   [5];
    logic [6:0]  t_q;
    state_t      state_q, state_d;
    logic        ack_q, irq_q, dv_q;
    logic [31:0] dat_q, rdata;
    logic [5:0]  idx;
    logic [3:0]  bi;
    logic [2:0]  di;
    logic        req, wr, start, blk_hit, dig_hit;
    logic        unused_adr;

    assign idx        = wbs_adr_i[7:2];
    assign bi         = idx[3:0] - 4'd4;
    assign di         = idx[2:0] - 3'd4;
    assign blk_hit    = (idx >= IDX_BLOCK) && (idx < IDX_DIGEST);
    assign dig_hit    = (idx >= IDX_DIGEST) && (idx < IDX_END);
    assign unused_adr = ^wbs_adr_i[1:0];
    // Gating with ack_q forces an idle cycle between acks of a held request
    assign req   = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~ack_q;
    assign wr    = req & wbs_we_i;
    assign start = wr & (idx == IDX_CTRL) & wbs_sel_i[0] & (|wbs_dat_i[1:0]) & (state_q == ST_IDLE);

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq_o     = irq_q;

    sha1_round u_round (
        .t_i (t_q),
        .a_i (wv_q[0]), .b_i (wv_q[1]), .c_i (wv_q[2]), .d_i (wv_q[3]), .e_i (wv_q[4]),
        .w_i (win_q[0]),
        .a_o (rnd[0]),  .b_o (rnd[1]),  .c_o (rnd[2]),  .d_o (rnd[3]),  .e_o (rnd[4])
    );

    always_comb begin
        for (int i = 0; i < 5; i++)
            hn[i] = wbs_dat_i[0] ? H_INIT[i] : h_q[i];
    end

    always_comb begin
        rdata = '0;
        if (idx == IDX_STATUS)
            rdata = {30'b0, dv_q, state_q == ST_IDLE};
        else if (blk_hit)
            rdata = blk_q[bi];
        else if (dig_hit)
            rdata = h_q[di];
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_IDLE && start)
            state_d = ST_ROUND;
        else if (state_q == ST_ROUND && t_q == 7'd79)
            state_d = ST_FINAL;
        else if (state_q == ST_FINAL)
            state_d = ST_IDLE;
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            blk_q <= '{default: '0};
            win_q <= '{default: '0};
            h_q   <= '{default: '0};
            wv_q  <= '{default: '0};
            t_q   <= '0;
            ack_q <= 1'b0;
            irq_q <= 1'b0;
            dv_q  <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= req;
            dat_q <= (req & ~wbs_we_i) ? rdata : '0;
            irq_q <= (state_q == ST_FINAL);
            if (wr && blk_hit)
                for (int b = 0; b < 4; b++)
                    if (wbs_sel_i[b])
                        blk_q[bi][8*b +: 8] <= wbs_dat_i[8*b +: 8];
            if (start) begin
                h_q   <= hn;
                wv_q  <= hn;
                win_q <= blk_q;
                t_q   <= '0;
                dv_q  <= 1'b0;
            end else if (state_q == ST_ROUND) begin
                wv_q <= rnd;
                t_q  <= t_q + 7'd1;
                // Window holds W[t..t+15]; append W[t+16] as the oldest word retires
                for (int i = 0; i < 15; i++)
                    win_q[i] <= win_q[i+1];
                win_q[15] <= rotl(win_q[13] ^ win_q[8] ^ win_q[2] ^ win_q[0], 1);
            end else if (state_q == ST_FINAL) begin
                for (int i = 0; i < 5; i++)
                    h_q[i] <= h_q[i] + wv_q[i];
                dv_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sha1_core_wb.sv
// tb_sha1_core_wb: directed known-answer and bus-rule tests for sha1_core_wb.
module tb_sha1_core_wb;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clock = 1'b0, resetb = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = '0;
    logic [31:0] adr = '0, dat = '0;
    logic [31:0] dat_o;
    logic        ack, irq;

    int n_chk = 0, n_fail = 0;

    logic [31:0] blk_abc [16], blk_empty [16], blk_m1 [16], blk_m2 [16];
    logic [31:0] d_abc [5]   = '{32'ha9993e36, 32'h4706816a, 32'hba3e2571, 32'h7850c26c, 32'h9cd0d89d};
    logic [31:0] d_empty [5] = '{32'hda39a3ee, 32'h5e6b4b0d, 32'h3255bfef, 32'h95601890, 32'hafd80709};
    logic [31:0] d_two [5]   = '{32'h84983e44, 32'h1c3bd26e, 32'hbaae4aa1, 32'hf95129e5, 32'he54670f1};
    logic [31:0] zero5 [5]   = '{default: 32'h0};

    sha1_core_wb dut (
        .clock     (clock),
        .resetb    (resetb),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (dat),
        .wbs_dat_o (dat_o),
        .wbs_ack_o (ack),
        .irq_o     (irq)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wb(input logic w, input logic [7:0] off, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] r);
        int n;
        @(negedge clock);
        cyc = 1'b1; stb = 1'b1; we = w; adr = BASE | {24'h0, off}; dat = d; sel = s;
        n = 0;
        do begin
            @(posedge clock); #1; n++;
        end while (!ack && n < 8);
        check($sformatf("ack_%02h", off), {31'b0, ack}, 32'd1);
        r = dat_o;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        logic [31:0] r;
        wb(1'b1, off, d, 4'hF, r);
    endtask

    task automatic rd(input logic [7:0] off, output logic [31:0] r);
        wb(1'b0, off, 32'h0, 4'hF, r);
    endtask

    task automatic load_block(input logic [31:0] b [16]);
        for (int i = 0; i < 16; i++)
            wr(8'(8'h10 + 4 * i), b[i]);
    endtask

    task automatic wait_irq(output int n);
        n = 0;
        do begin
            @(posedge clock); #1; n++;
        end while (!irq && n < 300);
        if (!irq)
            check("irq_timeout", 32'd0, 32'd1);
        @(posedge clock); #1;
        check("irq_one_pulse", {31'b0, irq}, 32'd0);
    endtask

    task automatic check_digest(input string tag, input logic [31:0] e [5]);
        logic [31:0] r;
        for (int i = 0; i < 5; i++) begin
            rd(8'(8'h50 + 4 * i), r);
            check($sformatf("%s_H%0d", tag, i), r, e[i]);
        end
    endtask

    task automatic run_abc(input string tag);
        int n;
        logic [31:0] r;
        load_block(blk_abc);
        wr(8'h00, 32'h1);
        wait_irq(n);
        check({tag, "_latency"}, n, 32'd81);
        rd(8'h04, r);
        check({tag, "_status"}, r, 32'd3);
        check_digest(tag, d_abc);
    endtask

    initial begin
        logic [31:0] r;
        int n;
        for (int i = 0; i < 16; i++) begin
            blk_abc[i] = '0; blk_empty[i] = '0; blk_m2[i] = '0;
        end
        blk_abc[0] = 32'h61626380; blk_abc[15] = 32'h00000018;
        blk_empty[0] = 32'h80000000;
        blk_m1 = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                   32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                   32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                   32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        blk_m2[15] = 32'h000001c0;

        repeat (3) @(posedge clock);
        #1;
        check("rst_ack", {31'b0, ack}, 32'd0);
        check("rst_dat", dat_o, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);
        @(negedge clock); resetb = 1'b1;
        rd(8'h04, r);  check("rst_status", r, 32'd1);
        check_digest("rst", zero5);

        rd(8'h80, r);  check("unmapped_rd", r, 32'd0);
        @(posedge clock); #1;
        check("ack_single", {31'b0, ack}, 32'd0);
        rd(8'h00, r);  check("ctrl_rd", r, 32'd0);
        wr(8'h1C, 32'h11223344);
        wb(1'b1, 8'h1C, 32'hAABBCCDD, 4'b0001, r);
        rd(8'h1C, r);  check("sel_byte0", r, 32'h112233DD);

        run_abc("abc");

        load_block(blk_empty);
        wr(8'h00, 32'h1);
        wait_irq(n);
        check("empty_latency", n, 32'd81);
        check_digest("empty", d_empty);

        load_block(blk_m1);
        wr(8'h00, 32'h1);
        wait_irq(n);
        load_block(blk_m2);
        wr(8'h00, 32'h2);
        wait_irq(n);
        check("next_latency", n, 32'd81);
        check_digest("two", d_two);

        load_block(blk_abc);
        wr(8'h00, 32'h1);
        wr(8'h00, 32'h2);
        wr(8'h10, 32'hFFFFFFFF);
        rd(8'h04, r);  check("busy_status", r, 32'd0);
        rd(8'h50, r);  check("busy_H0", r, 32'h67452301);
        wait_irq(n);
        check_digest("busy", d_abc);
        rd(8'h10, r);  check("busy_blk_write", r, 32'hFFFFFFFF);

        load_block(blk_abc);
        wr(8'h00, 32'h1);
        repeat (40) @(posedge clock);
        @(negedge clock); resetb = 1'b0;
        #1;
        check("abort_ack", {31'b0, ack}, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        check("abort_irq", {31'b0, irq}, 32'd0);
        @(negedge clock); resetb = 1'b1;
        rd(8'h04, r);  check("abort_status", r, 32'd1);
        check_digest("abort", zero5);
        rd(8'h10, r);  check("abort_blk0", r, 32'd0);
        run_abc("rerun");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
